mem_reader: RTL and testbench

//  Read-side engine for the 16K x 8 single-port frame RAM. Walks a programmable address

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_reader_if.sv | 38 +++
 rtl/mem_reader.sv | 86 ++++++++
 tb/tb_mem_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
//==============================================================================
// Module : mem_pkg
// Brief  : Shared widths, state encoding and address type for the frame-RAM
//          read/write engines.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } rd_state_t;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

`default_nettype wire

// File: rtl/mem_reader_if.sv
//==============================================================================
// Module : mem_reader_if
// Brief  : Control, RAM read port and output stream of the frame-RAM reader.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface mem_reader_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Reader side
    modport master (
        input  start, stop, base_addr, length, q, out_ready,
        output rd_addr, rd_en, out_data, out_valid, busy, done
    );

    // Controller / RAM / consumer side
    modport slave (
        output start, stop, base_addr, length, q, out_ready,
        input  rd_addr, rd_en, out_data, out_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/mem_reader.sv
//==============================================================================
// Module : mem_reader
// Brief  : Walks an address range of the frame RAM one read at a time and
//          streams each byte out on a valid/ready handshake.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_reader #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_reader_if.master  bus
);
    import mem_pkg::*;

    localparam int              CNT_W       = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W:0]  c_one       = (ADDR_W+1)'(1);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [CNT_W-1:0]  r_wait;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;
    logic              w_hs;
    logic              w_last_wait;

    assign w_accept    = (r_state == ST_IDLE) && bus.start && !bus.stop;
    assign w_hs        = (r_state == ST_PRESENT) && bus.out_ready;
    assign w_last_wait = (r_state == ST_WAIT) && (r_wait == c_wait_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = (bus.length == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:   w_next = ST_WAIT;
            ST_WAIT:    if (r_wait == c_wait_last) w_next = ST_PRESENT;
            ST_PRESENT: if (w_hs) w_next = (r_remaining == c_one) ? ST_DONE : ST_ISSUE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        // Abort overrides every other transition
        if (bus.stop) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= ((r_state == ST_WAIT) && (w_next == ST_WAIT)) ? r_wait + 1'b1 : '0;
            if (w_accept) begin
                r_addr      <= bus.base_addr;
                r_remaining <= bus.length;
            end
            if (w_last_wait) begin
                r_data <= bus.q;
            end
            // Address wraps naturally at 2^ADDR_W
            if (w_hs && (r_remaining != c_one)) begin
                r_remaining <= r_remaining - c_one;
                r_addr      <= r_addr + 1'b1;
            end
        end
    end

    assign bus.rd_addr   = r_addr;
    assign bus.rd_en     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.out_data  = r_data;
    assign bus.out_valid = (r_state == ST_PRESENT);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem_reader.sv
//==============================================================================
// Module : tb_mem_reader
// Brief  : Directed self-checking bench; three readers with RD_LAT=1,2,3.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic        stop;
    logic [13:0] base;
    logic [14:0] len;
    logic        rdy_main;
    bit          sweep_on;
    logic [7:0]  mem [16384];

    logic [2:0]  v_a, en_a, busy_a, done_a;
    logic [7:0]  dat_a [3];
    logic [13:0] adr_a [3];
    int          sw_n [3], sw_derr [3], sw_lerr [3], sw_gaps [3], sw_done [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lat
        localparam int LAT = gi + 1;

        mem_reader_if bus ();
        logic [7:0]  pipe [LAT];
        logic        rr;
        int          cnt_n, derr, lerr, gap, ngap, ndone;

        assign bus.start     = start[gi];
        assign bus.stop      = stop;
        assign bus.base_addr = base;
        assign bus.length    = len;
        assign bus.out_ready = sweep_on ? rr : (gi == 0 ? rdy_main : 1'b0);
        assign bus.q         = pipe[LAT-1];

        always @(posedge clk) begin
            pipe[0] <= mem[bus.rd_addr];
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end

        mem_reader #(.ADDR_W(14), .DATA_W(8), .RD_LAT(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        // Random consumer for the latency sweep; gap = low-valid cycles while busy
        always @(negedge clk) begin : mon
            bit w;
            if (!sweep_on) begin
                rr <= 1'b0; cnt_n <= 0; derr <= 0; lerr <= 0;
                gap <= 0; ngap <= 0; ndone <= 0;
            end else begin
                w = ($urandom_range(0, 2) != 0);
                rr <= w;
                if (!bus.busy) gap <= 0;
                else if (!bus.out_valid) gap <= gap + 1;
                else if (gap != 0) begin
                    if (gap + 1 != LAT + 2) lerr <= lerr + 1;
                    ngap <= ngap + 1;
                    gap  <= 0;
                end
                if (bus.out_valid && w) begin
                    if (bus.out_data != mem[14'(base + cnt_n)]) derr <= derr + 1;
                    cnt_n <= cnt_n + 1;
                end
                if (bus.done) ndone <= ndone + 1;
            end
        end

        assign v_a[gi]     = bus.out_valid;
        assign en_a[gi]    = bus.rd_en;
        assign busy_a[gi]  = bus.busy;
        assign done_a[gi]  = bus.done;
        assign dat_a[gi]   = bus.out_data;
        assign adr_a[gi]   = bus.rd_addr;
        assign sw_n[gi]    = cnt_n;
        assign sw_derr[gi] = derr;
        assign sw_lerr[gi] = lerr;
        assign sw_gaps[gi] = ngap;
        assign sw_done[gi] = ndone;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    endtask

    // Runs one transfer on the RD_LAT=1 reader; call right after a falling edge
    task automatic xfer(input string tag, input logic [13:0] b, input logic [14:0] l,
                        input int bp_idx, input int bp_len, input bit collide,
                        output int first_lat, output int done_at);
        int nbytes = 0, ndone = 0, derr = 0, aerr = 0, serr = 0, nrd = 0, hold = 0, cyc = 0;
        bit prev_en = 1'b0, fin = 1'b0;
        logic [7:0] held = '0;
        first_lat = 0;
        done_at   = 0;
        base = b; len = l; rdy_main = 1'b1; start[0] = 1'b1;
        while (!fin && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            start[0] = 1'b0;
            if (collide && cyc == 2) begin
                start[0] = 1'b1; base = b + 14'h200; len = 15'd2;
            end
            if (v_a[0] && first_lat == 0) first_lat = cyc;
            if (done_a[0]) begin ndone++; if (done_at == 0) done_at = cyc; end
            if (en_a[0] && !prev_en) begin
                if (adr_a[0] != 14'(b + nrd)) aerr++;
                nrd++;
            end
            prev_en  = en_a[0];
            rdy_main = 1'b1;
            if (nbytes == bp_idx && hold > 0 && hold < bp_len && !v_a[0]) serr++;
            if (v_a[0] && nbytes == bp_idx && hold < bp_len) begin
                if (hold > 0 && (dat_a[0] != held || en_a[0])) serr++;
                held = dat_a[0]; hold++; rdy_main = 1'b0;
            end
            if (v_a[0] && rdy_main) begin
                if (dat_a[0] != mem[14'(b + nbytes)]) derr++;
                nbytes++;
            end
            if (!busy_a[0]) fin = 1'b1;
        end
        check_val({tag, "_finished"}, 32'(fin), 1);
        check_val({tag, "_bytes"}, nbytes, 32'(l));
        check_val({tag, "_reads"}, nrd, 32'(l));
        check_val({tag, "_data_errs"}, derr, 0);
        check_val({tag, "_addr_errs"}, aerr, 0);
        check_val({tag, "_done_pulses"}, ndone, 1);
        if (bp_len > 0) begin
            check_val({tag, "_stall_cycles"}, hold, bp_len);
            check_val({tag, "_stall_errs"}, serr, 0);
        end
        rdy_main = 1'b0;
    endtask

    initial begin : main
        int lat, dn, k, seen;
        rst = 1'b0; start = '0; stop = 1'b0; base = '0; len = '0;
        rdy_main = 1'b0; sweep_on = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[16'h10] = 8'hA0; mem[16'h11] = 8'hA1; mem[16'h12] = 8'hA2; mem[16'h13] = 8'hA3;
        repeat (3) @(negedge clk);

        check_val("reset_busy",  32'(busy_a), 0);
        check_val("reset_valid", 32'(v_a), 0);
        check_val("reset_rd_en", 32'(en_a), 0);
        check_val("reset_done",  32'(done_a), 0);
        check_val("reset_data",  32'(dat_a[0]), 0);
        check_val("reset_addr",  32'(adr_a[0]), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic four-byte read, free-flowing consumer
        xfer("basic", 14'h10, 15'd4, -1, 0, 1'b0, lat, dn);
        check_val("basic_first_valid_cycle", lat, 1 + 2);

        // Consumer stalls five cycles on the second byte
        xfer("bp", 14'h10, 15'd4, 1, 5, 1'b0, lat, dn);

        // Address wrap at the top of the RAM
        xfer("wrap", 14'h3FFE, 15'd3, -1, 0, 1'b0, lat, dn);

        // Zero length: done without touching the RAM
        xfer("len0", 14'h55, 15'd0, -1, 0, 1'b0, lat, dn);
        check_val("len0_done_cycle", dn, 1);
        check_val("len0_valid_never", lat, 0);

        // start while busy must not disturb the running transfer
        xfer("busy_start", 14'h10, 15'd4, -1, 0, 1'b1, lat, dn);

        // Whole RAM in one pass
        xfer("full", 14'h0, 15'd16384, -1, 0, 1'b0, lat, dn);

        // Abort during WAIT
        base = 14'h20; len = 15'd4; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        @(negedge clk);
        check_val("stop_pre_rd_en", 32'(en_a[0]), 1);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check_val("stop_busy",  32'(busy_a[0]), 0);
        check_val("stop_rd_en", 32'(en_a[0]), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (v_a[0] || done_a[0]) seen++;
            @(negedge clk);
        end
        check_val("stop_no_valid_or_done", seen, 0);

        // stop together with start in IDLE
        start[0] = 1'b1; stop = 1'b1; len = 15'd4;
        @(negedge clk); start[0] = 1'b0; stop = 1'b0;
        check_val("stopstart_busy",  32'(busy_a[0]), 0);
        check_val("stopstart_rd_en", 32'(en_a[0]), 0);
        @(negedge clk);
        check_val("stopstart_busy_later", 32'(busy_a[0]), 0);

        // Asynchronous reset while a byte is presented
        base = 14'h10; len = 15'd4; rdy_main = 1'b0; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_pre_valid", 32'(v_a[0]), 1);
        #2 rst = 1'b0;
        #1;
        check_val("rst_async_valid", 32'(v_a[0]), 0);
        check_val("rst_async_busy",  32'(busy_a[0]), 0);
        check_val("rst_async_data",  32'(dat_a[0]), 0);
        check_val("rst_async_addr",  32'(adr_a[0]), 0);
        check_val("rst_async_rd_en", 32'(en_a[0]), 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_val("rst_release_busy", 32'(busy_a[0]), 0);

        // Latency sweep across the three readers with a random consumer
        base = 14'h100; len = 15'd16; sweep_on = 1'b1;
        @(negedge clk); start = 3'b111;
        @(negedge clk); start = 3'b000;
        k = 0;
        while (busy_a != 3'b000 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("sweep_finished", 32'(k < 2000), 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("sweep_lat%0d_bytes", i + 1), sw_n[i], 16);
            check_val($sformatf("sweep_lat%0d_data_errs", i + 1), sw_derr[i], 0);
            check_val($sformatf("sweep_lat%0d_gaps", i + 1), sw_gaps[i], 16);
            check_val($sformatf("sweep_lat%0d_gap_errs", i + 1), sw_lerr[i], 0);
            check_val($sformatf("sweep_lat%0d_done", i + 1), sw_done[i], 1);
        end
        sweep_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
